accumulator_ctrl: RTL and testbench



---
 rtl/accumulator_ctrl_pkg.sv | 18 +
 rtl/ripple_carry_adder.sv | 22 ++
 rtl/accumulator_ctrl.sv | 155 +++++++++++++++
 tb/tb_accumulator_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/accumulator_ctrl_pkg.sv
// Shared widths and FSM state encodings for the accumulator control block.
package accumulator_ctrl_pkg;

    localparam int ACC_W  = 5;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Zero-extend a sample to the accumulator width for the adder's B input.
    function automatic logic [ACC_W-1:0] zext_sample(input logic [DATA_W-1:0] sample);
        return {{(ACC_W-DATA_W){1'b0}}, sample};
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 5-bit ripple-carry adder: chain of full adders, carry-in forced to zero.
module ripple_carry_adder
    import accumulator_ctrl_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             cout
);

    logic [ACC_W:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < ACC_W; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign cout = carry_s[ACC_W];

endmodule

// File: rtl/accumulator_ctrl.sv
// Accumulator control: holds the running sum, accepts samples via valid/ready,
// counts them, tracks wrap-around and signals completion of a run.
module accumulator_ctrl
    import accumulator_ctrl_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              overflow,
    output logic              done
);

    state_t             state_r;
    state_t             state_next_s;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_r;
    logic               in_ready_r;
    logic               done_r;
    logic               in_ready_s;
    logic               done_s;
    logic [ACC_W-1:0]   sum_s;
    logic               carry_s;
    logic               accept_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               last_s;

    // The adder sees the live accumulator and the zero-extended sample.
    ripple_carry_adder u_adder (
        .a    (acc_r),
        .b    (zext_sample(in_data)),
        .sum  (sum_s),
        .cout (carry_s)
    );

    assign accept_s  = in_valid && (state_r == ST_ACCUM);
    assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign last_s    = (cnt_inc_s == CNT_W'(NUM_SAMPLES));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the next state so their registers track state_r.
    always_comb begin
        in_ready_s = 1'b0;
        done_s     = 1'b0;
        case (state_next_s)
            ST_ACCUM: begin
                in_ready_s = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                done_s     = 1'b0;
            end
        endcase
    end

    // Output flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= in_ready_s;
            done_r     <= done_s;
        end
    end

    // Accumulator, sample counter and sticky wrap flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            ovf_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        acc_r <= {ACC_W{1'b0}};
                        cnt_r <= {CNT_W{1'b0}};
                        ovf_r <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_r <= sum_s;
                        cnt_r <= cnt_inc_s;
                        // carry out of the top bit is exactly SUM < acc
                        ovf_r <= ovf_r | carry_s;
                    end
                end
                default: begin
                    acc_r <= {ACC_W{1'b0}};
                    cnt_r <= {CNT_W{1'b0}};
                    ovf_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign done       = done_r;
    assign acc_out    = acc_r;
    assign sample_cnt = cnt_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Directed self-checking bench for accumulator_ctrl (NUM_SAMPLES=4).
module tb_accumulator_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [4:0] acc_out;
    logic [2:0] sample_cnt;
    logic       overflow;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    accumulator_ctrl #(.NUM_SAMPLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .acc_out    (acc_out),
        .sample_cnt (sample_cnt),
        .overflow   (overflow),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_acc, input int e_cnt,
                             input int e_ovf, input int e_rdy, input int e_done);
        check({tag, ".acc"},   int'(acc_out),    e_acc);
        check({tag, ".cnt"},   int'(sample_cnt), e_cnt);
        check({tag, ".ovf"},   int'(overflow),   e_ovf);
        check({tag, ".ready"}, int'(in_ready),   e_rdy);
        check({tag, ".done"},  int'(done),       e_done);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [3:0] d);
        start    = s;
        in_valid = v;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0);
        #2;
        check_all("reset", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all("idle", 0, 0, 0, 0, 0);

        // Test 1: 3,5,7,9 back-to-back
        drive(1'b1, 1'b0, 4'd0); step();
        check_all("t1.start", 0, 0, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd3); step(); check_all("t1.s1", 3, 1, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd5); step(); check_all("t1.s2", 8, 2, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd7); step(); check_all("t1.s3", 15, 3, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd9); step(); check_all("t1.s4", 24, 4, 0, 0, 1);

        // Test 2: wrap-around 15,15,15,1
        drive(1'b1, 1'b0, 4'd0); step();
        check_all("t2.start", 0, 0, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd15); step(); check_all("t2.s1", 15, 1, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd15); step(); check_all("t2.s2", 30, 2, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd15); step(); check_all("t2.s3", 13, 3, 1, 1, 0);
        drive(1'b0, 1'b1, 4'd1);  step(); check_all("t2.s4", 14, 4, 1, 0, 1);

        // Test 3: gapped valid pattern
        drive(1'b1, 1'b0, 4'd0); step();
        check_all("t3.start", 0, 0, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd2);  step(); check_all("t3.c1", 2, 1, 0, 1, 0);
        drive(1'b0, 1'b0, 4'd11); step(); check_all("t3.c2", 2, 1, 0, 1, 0);
        drive(1'b0, 1'b0, 4'd7);  step(); check_all("t3.c3", 2, 1, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd4);  step(); check_all("t3.c4", 6, 2, 0, 1, 0);
        drive(1'b0, 1'b0, 4'd13); step(); check_all("t3.c5", 6, 2, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd6);  step(); check_all("t3.c6", 12, 3, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd8);  step(); check_all("t3.c7", 20, 4, 0, 0, 1);

        // Test 4: start ignored in ACCUM, honoured in DONE
        drive(1'b1, 1'b0, 4'd0); step();
        drive(1'b0, 1'b1, 4'd1); step();
        drive(1'b0, 1'b1, 4'd1); step(); check_all("t4.two", 2, 2, 0, 1, 0);
        drive(1'b1, 1'b0, 4'd0); step(); check_all("t4.startacc", 2, 2, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd1); step(); check_all("t4.s3", 3, 3, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd1); step(); check_all("t4.s4", 4, 4, 0, 0, 1);
        drive(1'b1, 1'b1, 4'd5); step(); check_all("t4.restart", 0, 0, 0, 1, 0);

        // Test 5: asynchronous reset mid-run (restart is already in ACCUM)
        drive(1'b0, 1'b1, 4'd5); step(); check_all("t5.s1", 5, 1, 0, 1, 0);
        drive(1'b0, 1'b1, 4'd5); step(); check_all("t5.s2", 10, 2, 0, 1, 0);
        #2 rst = 1'b1;
        #1 check_all("t5.async", 0, 0, 0, 0, 0);
        #1 rst = 1'b0;

        // Test 6a: IDLE ignores in_valid
        drive(1'b0, 1'b1, 4'd9);
        for (int i = 0; i < 5; i++) begin
            step();
            check_all("t6.idle", 0, 0, 0, 0, 0);
        end

        // Test 6b: DONE holds its result while in_valid is high
        drive(1'b1, 1'b0, 4'd0); step();
        drive(1'b0, 1'b1, 4'd1); step();
        drive(1'b0, 1'b1, 4'd2); step();
        drive(1'b0, 1'b1, 4'd3); step();
        drive(1'b0, 1'b1, 4'd4); step(); check_all("t6.fin", 10, 4, 0, 0, 1);
        drive(1'b0, 1'b1, 4'd9);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("t6.done", 10, 4, 0, 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
